// File: rtl/if_id_queue_if.sv
// Fetch-to-decode queue bus: fetch push handshake, decode pop handshake, flush and occupancy.
interface if_id_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [31:0]   in_instr;
  logic [31:0]   in_pc;
  logic          in_pred_taken;
  logic          in_ready;
  logic          flush;
  logic          out_valid;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic          out_pred_taken;
  logic          out_ready;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_instr, in_pc, in_pred_taken, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_pred_taken, count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_pred_taken, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_pred_taken, count
  );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: in-order FIFO of {pc, instr, pred_taken} between fetch and decode,
// back-pressuring fetch when full and discarding every wrong-path entry on flush.
module if_id_queue #(
  parameter int unsigned DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst,
  if_id_queue_if.slave q
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred_taken;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic   full_c, empty_c, push_c, pop_c;
  entry_t wr_entry_c, head_c;

  // Handshake qualification; flush suppresses both sides, full blocks push even with a pop.
  always_comb begin
    full_c     = (count_q == CW'(DEPTH));
    empty_c    = (count_q == '0);
    push_c     = q.in_valid && !full_c && !q.flush;
    pop_c      = !empty_c && q.out_ready && !q.flush;
    wr_entry_c = '{pc: q.in_pc, instr: q.in_instr, pred_taken: q.in_pred_taken};
  end

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is intentionally not reset; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= wr_entry_c;
  end

  assign head_c           = mem_q[rd_ptr_q];
  assign q.in_ready       = !full_c;
  assign q.out_valid      = !empty_c;
  assign q.out_instr      = empty_c ? NOP   : head_c.instr;
  assign q.out_pc         = empty_c ? 32'h0 : head_c.pc;
  assign q.out_pred_taken = empty_c ? 1'b0  : head_c.pred_taken;
  assign q.count          = count_q;
endmodule
